// File: rtl/eq_pkg.sv
// eq_pkg: shared types for the four-valued equality stage.
//   tri_t    : three-state comparison outcome (T0 / T1 / TX)
//   op_t     : comparison opcode (==, !=, ===, !==)
//   tri_not  : logical negation of a three-state value; TX stays TX
package eq_pkg;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    TX = 2'b10
  } tri_t;

  typedef enum logic [1:0] {
    EQ  = 2'd0,
    NE  = 2'd1,
    CEQ = 2'd2,
    CNE = 2'd3
  } op_t;

  function automatic tri_t tri_not(input tri_t t);
    case (t)
      T0:      return T1;
      T1:      return T0;
      default: return TX;
    endcase
  endfunction

endpackage

// File: rtl/eq_stage_pipe_if.sv
// eq_stage_pipe_if: operand/result handshake bundle for eq_stage_pipe.
//   in_*      : operand pair (value + unknown mask + signedness per side), valid/ready
//   out_*     : three-state result stream, valid/ready
//   cnt_*     : running outcome tallies
//   clr       : synchronous tally clear
// master = producer/consumer side, slave = the stage itself.
interface eq_stage_pipe_if #(
  parameter int WA = 8,
  parameter int WB = 8,
  parameter int CW = 16
);
  import eq_pkg::*;

  logic          in_valid;
  logic          in_ready;
  op_t           in_op;
  logic [WA-1:0] a_val;
  logic [WA-1:0] a_xm;
  logic          a_signed;
  logic [WB-1:0] b_val;
  logic [WB-1:0] b_xm;
  logic          b_signed;
  logic          out_valid;
  logic          out_ready;
  tri_t          out_res;
  logic [CW-1:0] cnt_true;
  logic [CW-1:0] cnt_false;
  logic [CW-1:0] cnt_x;
  logic          clr;

  modport master (
    output in_valid, in_op, a_val, a_xm, a_signed, b_val, b_xm, b_signed,
           out_ready, clr,
    input  in_ready, out_valid, out_res, cnt_true, cnt_false, cnt_x
  );

  modport slave (
    input  in_valid, in_op, a_val, a_xm, a_signed, b_val, b_xm, b_signed,
           out_ready, clr,
    output in_ready, out_valid, out_res, cnt_true, cnt_false, cnt_x
  );

endinterface

// File: rtl/eq_extend.sv
// eq_extend: widens one operand (value + unknown mask) from WI to WO bits.
//   val_i/xm_i  : operand value and unknown mask
//   sgn_i       : this operand is signed
//   peer_sgn_i  : the other operand is signed
//   val_o/xm_o  : extended value and mask
// Sign extension happens only when both sides are signed; the mask bit
// follows the MSB so an unknown sign bit yields unknown extension bits.
module eq_extend #(
  parameter int WI = 8,
  parameter int WO = 8
) (
  input  logic [WI-1:0] val_i,
  input  logic [WI-1:0] xm_i,
  input  logic          sgn_i,
  input  logic          peer_sgn_i,
  output logic [WO-1:0] val_o,
  output logic [WO-1:0] xm_o
);

  logic sx;
  assign sx = sgn_i & peer_sgn_i;

  always_comb begin
    val_o = WO'(val_i);
    xm_o  = WO'(xm_i);
    if (sx) begin
      for (int i = WI; i < WO; i++) begin
        val_o[i] = val_i[WI-1];
        xm_o[i]  = xm_i[WI-1];
      end
    end
  end

endmodule

// File: rtl/eq_stage_pipe.sv
// eq_stage_pipe: two-stage pipelined four-valued equality.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : eq_stage_pipe_if slave -- operand pair in, three-state result
//              out, outcome tallies, tally clear
// Stage 1 holds the extended operands and opcode; stage 2 holds the result.
// Tallies count output handshakes by class and saturate.
module eq_stage_pipe
  import eq_pkg::*;
#(
  parameter int WA = 8,
  parameter int WB = 8,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  eq_stage_pipe_if.slave  bus
);

  localparam int W = (WA > WB) ? WA : WB;

  logic [W-1:0] a_val_d, a_xm_d, b_val_d, b_xm_d;

  eq_extend #(.WI(WA), .WO(W)) u_ext_a (
    .val_i(bus.a_val), .xm_i(bus.a_xm), .sgn_i(bus.a_signed),
    .peer_sgn_i(bus.b_signed), .val_o(a_val_d), .xm_o(a_xm_d)
  );

  eq_extend #(.WI(WB), .WO(W)) u_ext_b (
    .val_i(bus.b_val), .xm_i(bus.b_xm), .sgn_i(bus.b_signed),
    .peer_sgn_i(bus.a_signed), .val_o(b_val_d), .xm_o(b_xm_d)
  );

  // ---- handshake ----
  logic s1_v_q, s2_v_q;
  logic s1_ld, s2_ld, hs;

  assign bus.in_ready = !s1_v_q || !s2_v_q || bus.out_ready;
  assign s1_ld        = bus.in_valid && bus.in_ready;
  assign s2_ld        = (!s2_v_q || bus.out_ready) && s1_v_q;
  assign hs           = s2_v_q && bus.out_ready;

  // ---- stage 1 ----
  logic [W-1:0] a_val_q, a_xm_q, b_val_q, b_xm_q;
  op_t          op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      op_q    <= EQ;
      a_val_q <= '0;
      a_xm_q  <= '0;
      b_val_q <= '0;
      b_xm_q  <= '0;
    end else begin
      if (s1_ld) begin
        s1_v_q  <= 1'b1;
        op_q    <= bus.in_op;
        a_val_q <= a_val_d;
        a_xm_q  <= a_xm_d;
        b_val_q <= b_val_d;
        b_xm_q  <= b_xm_d;
      end else if (s2_ld) begin
        s1_v_q  <= 1'b0;
      end
    end
  end

  // ---- compare ----
  tri_t res_d, eq_r;
  logic any_x, val_eq, case_eq;

  always_comb begin
    any_x   = |a_xm_q || |b_xm_q;
    val_eq  = (a_val_q == b_val_q);
    // === : masks must agree; value bits under a set mask are don't-care
    case_eq = (a_xm_q == b_xm_q) && (((a_val_q ^ b_val_q) & ~a_xm_q) == '0);
    eq_r    = any_x ? TX : (val_eq ? T1 : T0);
    res_d   = T0;
    case (op_q)
      EQ:      res_d = eq_r;
      NE:      res_d = tri_not(eq_r);
      CEQ:     res_d = case_eq ? T1 : T0;
      default: res_d = case_eq ? T0 : T1;
    endcase
  end

  // ---- stage 2 ----
  tri_t res_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q <= 1'b0;
      res_q  <= T0;
    end else begin
      if (s2_ld) begin
        s2_v_q <= 1'b1;
        res_q  <= res_d;
      end else if (bus.out_ready) begin
        s2_v_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = s2_v_q;
  assign bus.out_res   = res_q;

  // ---- outcome tallies: [0]=true [1]=false [2]=x ----
  logic [2:0] inc;
  assign inc = {hs && (res_q == TX), hs && (res_q == T0), hs && (res_q == T1)};

  for (genvar k = 0; k < 3; k++) begin : g_cnt
    logic [CW-1:0] cnt_q;
    // clr has priority over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                          cnt_q <= '0;
      else if (bus.clr)                 cnt_q <= '0;
      else if (inc[k] && cnt_q != '1)   cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bus.cnt_true  = g_cnt[0].cnt_q;
  assign bus.cnt_false = g_cnt[1].cnt_q;
  assign bus.cnt_x     = g_cnt[2].cnt_q;

endmodule

// File: tb/tb_eq_stage_pipe.sv
module tb_eq_stage_pipe;
  import eq_pkg::*;

  localparam int MWA = 8, MWB = 6, MCW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eq_stage_pipe_if #(.WA(MWA), .WB(MWB), .CW(MCW)) if_m ();
  eq_stage_pipe    #(.WA(MWA), .WB(MWB), .CW(MCW)) dut_m (.clk(clk), .rst(rst), .bus(if_m));

  eq_stage_pipe_if #(.WA(1), .WB(2), .CW(4)) if_n ();
  eq_stage_pipe    #(.WA(1), .WB(2), .CW(4)) dut_n (.clk(clk), .rst(rst), .bus(if_n));

  int nchk = 0, npass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: widen by the signedness rule, then apply the operator rules.
  // Result encoding: 0=T0, 1=T1, 2=TX.
  function automatic logic [1:0] ref_res(input int wa, input int wb, input logic [1:0] op,
      input logic [31:0] av, input logic [31:0] am, input logic as,
      input logic [31:0] bv, input logic [31:0] bm, input logic bs);
    longint unsigned w, wmask, ea, eam, eb, ebm;
    logic sx, eq, ceq;
    w     = (wa > wb) ? wa : wb;
    wmask = (64'd1 << w) - 1;
    sx    = as && bs;
    ea  = av & ((64'd1 << wa) - 1);  eam = am & ((64'd1 << wa) - 1);
    eb  = bv & ((64'd1 << wb) - 1);  ebm = bm & ((64'd1 << wb) - 1);
    if (sx && ea[wa-1])  ea  |= ~((64'd1 << wa) - 1);
    if (sx && eam[wa-1]) eam |= ~((64'd1 << wa) - 1);
    if (sx && eb[wb-1])  eb  |= ~((64'd1 << wb) - 1);
    if (sx && ebm[wb-1]) ebm |= ~((64'd1 << wb) - 1);
    ea &= wmask; eam &= wmask; eb &= wmask; ebm &= wmask;
    eq  = (ea == eb);
    ceq = (eam == ebm) && (((ea ^ eb) & ~eam) == 0);
    case (op)
      2'd0: return (eam != 0 || ebm != 0) ? 2'd2 : (eq ? 2'd1 : 2'd0);
      2'd1: return (eam != 0 || ebm != 0) ? 2'd2 : (eq ? 2'd0 : 2'd1);
      2'd2: return ceq ? 2'd1 : 2'd0;
      default: return ceq ? 2'd0 : 2'd1;
    endcase
  endfunction

  logic [1:0] q[$];
  int mt = 0, mf = 0, mx = 0;
  logic last_acc;

  // One cycle on the main DUT: drive at negedge, record handshakes, step to next negedge.
  task automatic cyc(input logic iv, input logic [1:0] op, input logic [31:0] av, input logic [31:0] am,
      input logic as, input logic [31:0] bv, input logic [31:0] bm, input logic bs,
      input logic ordy, input logic cl);
    logic acc, emt;
    logic [1:0] e;
    if_m.in_valid = iv; if_m.in_op = op_t'(op);
    if_m.a_val = av[MWA-1:0]; if_m.a_xm = am[MWA-1:0]; if_m.a_signed = as;
    if_m.b_val = bv[MWB-1:0]; if_m.b_xm = bm[MWB-1:0]; if_m.b_signed = bs;
    if_m.out_ready = ordy; if_m.clr = cl;
    #1;
    acc = iv && if_m.in_ready;
    emt = if_m.out_valid && ordy;
    last_acc = acc;
    e = 2'd0;
    if (if_m.out_valid) begin
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else chk("res", if_m.out_res, q[0]);
    end
    if (emt && q.size() > 0) e = q.pop_front();
    if (acc) q.push_back(ref_res(MWA, MWB, op, av, am, as, bv, bm, bs));
    if (cl) begin mt = 0; mf = 0; mx = 0; end
    else if (emt) begin
      if (e == 2'd1 && mt < 65535) mt++;
      if (e == 2'd0 && mf < 65535) mf++;
      if (e == 2'd2 && mx < 65535) mx++;
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_t"}, if_m.cnt_true, mt);
    chk({tag, "_f"}, if_m.cnt_false, mf);
    chk({tag, "_x"}, if_m.cnt_x, mx);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic ncyc(input logic iv, input logic [1:0] op, input logic av, input logic [1:0] bv,
      input logic as, input logic bs, input logic ordy, input logic cl);
    if_n.in_valid = iv; if_n.in_op = op_t'(op);
    if_n.a_val = av; if_n.a_xm = 1'b0; if_n.a_signed = as;
    if_n.b_val = bv; if_n.b_xm = 2'b00; if_n.b_signed = bs;
    if_n.out_ready = ordy; if_n.clr = cl;
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    logic [31:0] av, am, bv, bm;
    logic [1:0] op;
    if_m.in_valid = 0; if_m.in_op = EQ; if_m.a_val = 0; if_m.a_xm = 0; if_m.a_signed = 0;
    if_m.b_val = 0; if_m.b_xm = 0; if_m.b_signed = 0; if_m.out_ready = 0; if_m.clr = 0;
    if_n.in_valid = 0; if_n.in_op = EQ; if_n.a_val = 0; if_n.a_xm = 0; if_n.a_signed = 0;
    if_n.b_val = 0; if_n.b_xm = 0; if_n.b_signed = 0; if_n.out_ready = 0; if_n.clr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ovalid", if_m.out_valid, 0);
    chk("rst_ores", if_m.out_res, 0);
    chk("rst_irdy", if_m.in_ready, 1);
    chk_cnt("rst_cnt");

    // Stream with latency: pair presented before edge 1 appears after edge 2.
    cyc(1, 0, 10, 0, 0, 10, 0, 0, 1, 0);
    chk("lat_e1", if_m.out_valid, 0);
    cyc(1, 0, 10, 0, 0, 20, 0, 0, 1, 0);
    chk("lat_e2", if_m.out_valid, 1);
    chk("stream0", if_m.out_res, 1);
    cyc(1, 1, 10, 0, 0, 20, 0, 0, 1, 0);
    chk("stream1", if_m.out_res, 0);
    cyc(1, 0, 10, 8'hFF, 0, 10, 0, 0, 1, 0);
    chk("stream2", if_m.out_res, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("stream3", if_m.out_res, 2);
    idle(2);
    chk("stream_cnt_t", if_m.cnt_true, 2);
    chk("stream_cnt_f", if_m.cnt_false, 1);
    chk("stream_cnt_x", if_m.cnt_x, 1);

    // Directed x / case-equality cases.
    cyc(1, 1, 10, 8'hFF, 0, 10, 0, 0, 1, 0);
    cyc(1, 2, 8'h0B, 8'h01, 0, 8'h0A, 8'h01, 0, 1, 0);
    chk("ne_x", if_m.out_res, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("ceq_mask", if_m.out_res, 1);
    idle(2);

    // Back-pressure: two accepted, third refused, result held.
    cyc(1, 0, 5, 0, 0, 5, 0, 0, 0, 0);
    cyc(1, 0, 5, 0, 0, 6, 0, 0, 0, 0);
    cyc(1, 1, 7, 0, 0, 7, 0, 0, 0, 0);
    chk("stall_rdy", last_acc, 0);
    cyc(1, 1, 7, 0, 0, 7, 0, 0, 0, 0);
    chk("stall_hold", if_m.out_res, 1);
    cyc(1, 1, 7, 0, 0, 7, 0, 0, 1, 0);
    chk("stall_acc", last_acc, 1);
    idle(4);
    chk("stall_drain", q.size(), 0);
    chk_cnt("stall_cnt");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      op = 2'($urandom_range(0, 3));
      av = $urandom;
      bv = ($urandom_range(0, 1) == 1) ? av : $urandom;
      am = ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 7)) : 32'd0;
      bm = ($urandom_range(0, 1) == 1) ? am : (($urandom_range(0, 3) == 0) ? $urandom : 32'd0);
      cyc(1'($urandom_range(0, 3) != 0), op, av, am, 1'($urandom), bv, bm, 1'($urandom),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
      if (i % 100 == 99) chk_cnt("rnd_cnt");
    end
    idle(4);
    chk("rnd_drain", q.size(), 0);
    chk_cnt("rnd_cnt_end");

    // Narrow instance: signedness rule, saturation, clr priority.
    ncyc(1, 0, 1'b1, 2'b11, 1, 0, 1, 0);
    ncyc(1, 0, 1'b1, 2'b11, 1, 1, 1, 0);
    chk("zext_t0", if_n.out_res, 0);
    ncyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("sext_t1", if_n.out_res, 1);
    for (int i = 0; i < 17; i++) ncyc(1, 0, 1'b1, 2'b11, 1, 1, 1, 0);
    ncyc(0, 0, 0, 0, 0, 0, 1, 0);
    ncyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("sat_true", if_n.cnt_true, 15);
    chk("sat_false", if_n.cnt_false, 1);
    ncyc(1, 0, 1'b1, 2'b11, 1, 1, 0, 0);
    ncyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("clr_pending", if_n.out_valid, 1);
    ncyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("clr_true", if_n.cnt_true, 0);
    chk("clr_false", if_n.cnt_false, 0);
    chk("clr_emitted", if_n.out_valid, 0);

    // Mid-operation reset with two pairs in flight.
    cyc(1, 0, 3, 0, 0, 3, 0, 0, 1, 0);
    cyc(1, 0, 3, 0, 0, 4, 0, 0, 0, 0);
    cyc(1, 0, 3, 0, 0, 3, 0, 0, 0, 0);
    chk("pre_rst_vld", if_m.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_vld", if_m.out_valid, 0);
    chk("rst_mid_t", if_m.cnt_true, 0);
    chk("rst_mid_f", if_m.cnt_false, 0);
    chk("rst_mid_x", if_m.cnt_x, 0);
    q.delete(); mt = 0; mf = 0; mx = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(4);
    chk("post_rst_vld", if_m.out_valid, 0);
    chk_cnt("post_rst_cnt");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
